// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor.
//   - state_e      : FSM state encoding, also driven out on the state port
//   - CYC_PER_US   : sys_clk cycles per microsecond (200 MHz)
//   - DEF_*        : default timing parameters derived from CYC_PER_US
//   - max3()       : helper for sizing the shared phase timer
package pll_mon_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam int CYC_PER_US         = 200;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_STABLE_CYCLES  = 10 * CYC_PER_US;    // 10 us
  localparam int DEF_LOCK_TIMEOUT   = 1000 * CYC_PER_US;  // 1 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous status bits.
//   clk_i : destination clock
//   rst_i : synchronous, active-high reset; both stages clear to 0
//   d_i   : asynchronous input bits
//   q_o   : synchronised output, two clk_i cycles behind d_i
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// PLL lock monitor and downstream reset sequencer.
// Pulses the PLL reset, waits for (synchronised) lock, qualifies lock as
// stable for STABLE_CYCLES, then releases rst_out. Loss of lock in RUN and
// lock timeouts restart the sequence and are counted (saturating).
// Ports:
//   sys_clk         : the only clock
//   reset           : synchronous, active-high
//   pll_locked      : PLL lock status, asynchronous to sys_clk
//   clear_count     : synchronous clear of both event counters (wins over inc)
//   pll_reset       : PLL reset, high only in RESET_PLL
//   rst_out         : downstream reset, low only in RUN
//   ready           : high only in RUN
//   state           : current FSM state (pll_mon_pkg::state_e encoding)
//   lock_loss_count : RUN -> lock-lost events, saturating
//   timeout_count   : WAIT_LOCK timeouts, saturating
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int CNT_W          = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             pll_locked,
  input  logic             clear_count,
  output logic             pll_reset,
  output logic             rst_out,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int TW = $clog2(max3(PLL_RST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT)) + 1;

  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             lk_s;
  logic             loss_ev;
  logic             to_ev;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk_i (sys_clk),
    .rst_i (reset),
    .d_i   (pll_locked),
    .q_o   (lk_s)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q    <= RESET_PLL;
      timer_q    <= '0;
      loss_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      loss_cnt_q <= loss_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    loss_ev = 1'b0;
    to_ev   = 1'b0;
    case (state_q)
      RESET_PLL: begin
        // lk_s is deliberately ignored here: the PLL is being reset.
        if (timer_q == PLL_RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the final timeout cycle still counts as lock.
        if (lk_s) begin
          state_d = STABLE;
        end else if (timer_q == TIMEOUT_LAST) begin
          state_d = RESET_PLL;
          to_ev   = 1'b1;
        end
      end
      STABLE: begin
        // A dropout here is treated as a glitch: requalify, do not count.
        if (!lk_s)                       state_d = WAIT_LOCK;
        else if (timer_q == STABLE_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lk_s) begin
          state_d = RESET_PLL;
          loss_ev = 1'b1;
        end
      end
      default: state_d = RESET_PLL;
    endcase

    // Timer restarts on every state entry, including STABLE -> WAIT_LOCK.
    timer_d = (state_d != state_q) ? '0 : timer_q + TW'(1);

    if (clear_count)                    loss_cnt_d = '0;
    else if (loss_ev && ~&loss_cnt_q)   loss_cnt_d = loss_cnt_q + CNT_W'(1);
    else                                loss_cnt_d = loss_cnt_q;

    if (clear_count)                    to_cnt_d = '0;
    else if (to_ev && ~&to_cnt_q)       to_cnt_d = to_cnt_q + CNT_W'(1);
    else                                to_cnt_d = to_cnt_q;
  end

  // Outputs decode straight from the state register so they move on the
  // same edge as the state.
  assign pll_reset       = (state_q == RESET_PLL);
  assign rst_out         = (state_q != RUN);
  assign ready           = (state_q == RUN);
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;
  assign timeout_count   = to_cnt_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
module tb_pll_lock_monitor;

  localparam int P    = 4;
  localparam int S    = 8;
  localparam int T    = 32;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          sys_clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          clear_count = 1'b0;
  logic          pll_reset;
  logic          rst_out;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] lock_loss_count;
  logic [CW-1:0] timeout_count;

  int n_chk  = 0;
  int n_fail = 0;

  pll_lock_monitor #(
    .PLL_RST_CYCLES (P),
    .STABLE_CYCLES  (S),
    .LOCK_TIMEOUT   (T),
    .CNT_W          (CW)
  ) dut (
    .sys_clk         (sys_clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .clear_count     (clear_count),
    .pll_reset       (pll_reset),
    .rst_out         (rst_out),
    .ready           (ready),
    .state           (state),
    .lock_loss_count (lock_loss_count),
    .timeout_count   (timeout_count)
  );

  // Clock
  always #5 sys_clk = ~sys_clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0d req=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // ---------------------------------------------------------------------
  // Behavioural reference: phase + remaining dwell budget, lock history
  // delayed by two samples, counters as saturating integers.
  // Phase numbers: 0 reset pll, 1 wait lock, 2 stable, 3 run.
  // ---------------------------------------------------------------------
  int m_phase, m_left, m_lol, m_to;
  int lk_hist[$];

  function automatic int dwell(input int ph);
    case (ph)
      0:       return P;
      1:       return T;
      2:       return S;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter(input int ph);
    m_phase = ph;
    m_left  = dwell(ph);
  endtask

  task automatic model_edge(input logic r, input logic lk, input logic clr);
    int s;
    bit to_ev, ll_ev;
    if (r) begin
      m_enter(0);
      m_lol = 0;
      m_to  = 0;
      lk_hist = '{0, 0};
      return;
    end
    s = lk_hist.pop_front();
    lk_hist.push_back(int'(lk));
    to_ev = 0;
    ll_ev = 0;
    m_left = m_left - 1;
    case (m_phase)
      0: if (m_left == 0) m_enter(1);
      1: if (s != 0) m_enter(2);
         else if (m_left == 0) begin to_ev = 1; m_enter(0); end
      2: if (s == 0) m_enter(1);
         else if (m_left == 0) m_enter(3);
      default: if (s == 0) begin ll_ev = 1; m_enter(0); end
    endcase
    if (clr) begin
      m_lol = 0;
      m_to  = 0;
    end else begin
      if (ll_ev) m_lol = sat(m_lol + 1);
      if (to_ev) m_to  = sat(m_to + 1);
    end
  endtask

  // Driver: apply inputs, clock once, advance model, compare #1 after edge.
  task automatic step(input logic r, input logic lk, input logic clr);
    reset       = r;
    pll_locked  = lk;
    clear_count = clr;
    @(posedge sys_clk);
    model_edge(r, lk, clr);
    #1;
    chk("mdl_state", 32'(state), m_phase);
    chk("mdl_pll_reset", 32'(pll_reset), (m_phase == 0) ? 1 : 0);
    chk("mdl_rst_out", 32'(rst_out), (m_phase != 3) ? 1 : 0);
    chk("mdl_ready", 32'(ready), (m_phase == 3) ? 1 : 0);
    chk("mdl_lock_loss", 32'(lock_loss_count), m_lol);
    chk("mdl_timeout", 32'(timeout_count), m_to);
  endtask

  task automatic wait_run(input string nm);
    for (int i = 0; i < 100; i++) begin
      if (state == 2'd3) break;
      step(0, 1, 0);
    end
    chk(nm, 32'(state), 3);
  endtask

  // Drop lock for one sample while in RUN; RESET_PLL shows after 3 edges.
  task automatic drop_in_run(input string nm);
    step(0, 0, 0);
    chk({nm, "_d1_state"}, 32'(state), 3);
    step(0, 1, 0);
    chk({nm, "_d2_state"}, 32'(state), 3);
    step(0, 1, 0);
    chk({nm, "_d3_state"}, 32'(state), 0);
    chk({nm, "_d3_rst_out"}, 32'(rst_out), 1);
  endtask

  typedef struct {
    logic       r, lk, clr;
    logic [1:0] st;
    logic       pr, ro, rdy;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int seg_left;
    logic lvl;

    // Scenario 1 as a cycle table: reset, then lock held from the start.
    tbl[0] = '{1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    for (int i = 1; i <= 3; i++)  tbl[i] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0};
    for (int i = 5; i <= 12; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1};

    #2;
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, tbl[i].lk, tbl[i].clr);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_pll_reset", i), 32'(pll_reset), 32'(tbl[i].pr));
      chk($sformatf("tbl%0d_rst_out", i), 32'(rst_out), 32'(tbl[i].ro));
      chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_counts", i), 32'({lock_loss_count, timeout_count}), 0);
    end

    // Scenario 2: never locks; 36-cycle retry period, timeout count saturates.
    step(1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 35; j++) step(0, 0, 0);
      chk($sformatf("s2_wait_state_%0d", k), 32'(state), 1);
      chk($sformatf("s2_before_to_%0d", k), 32'(timeout_count), sat(k - 1));
      step(0, 0, 0);
      chk($sformatf("s2_retry_state_%0d", k), 32'(state), 0);
      chk($sformatf("s2_after_to_%0d", k), 32'(timeout_count), sat(k));
    end

    // Scenario 3: one-cycle dropout at STABLE timer 5 -> requalify.
    step(1, 1, 0);
    for (int j = 0; j < 10; j++) step(0, 1, 0);
    chk("s3_in_stable", 32'(state), 2);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("s3_still_stable", 32'(state), 2);
    step(0, 1, 0);
    chk("s3_back_wait", 32'(state), 1);
    chk("s3_rst_out", 32'(rst_out), 1);
    chk("s3_counts", 32'({lock_loss_count, timeout_count}), 0);
    step(0, 1, 0);
    chk("s3_restable", 32'(state), 2);
    for (int j = 0; j < 7; j++) step(0, 1, 0);
    chk("s3_full_qual", 32'(state), 2);
    step(0, 1, 0);
    chk("s3_run", 32'(state), 3);
    chk("s3_ready", 32'(ready), 1);

    // Scenario 4: lock lost in RUN.
    drop_in_run("s4");
    chk("s4_pll_reset", 32'(pll_reset), 1);
    chk("s4_lol", 32'(lock_loss_count), 1);
    for (int j = 0; j < 3; j++) step(0, 1, 0);
    chk("s4_pll_rst_4th", 32'(state), 0);
    step(0, 1, 0);
    chk("s4_wait", 32'(state), 1);
    step(0, 1, 0);
    chk("s4_stable", 32'(state), 2);
    for (int j = 0; j < 7; j++) step(0, 1, 0);
    chk("s4_stable_end", 32'(state), 2);
    step(0, 1, 0);
    chk("s4_relock_run", 32'(state), 3);
    chk("s4_lol_hold", 32'(lock_loss_count), 1);

    // Scenario 5: clear_count on the same edge as a timeout increment.
    for (int j = 0; j < 3; j++) step(0, 0, 0);
    chk("s5_lol2", 32'(lock_loss_count), 2);
    for (int j = 0; j < 36; j++) step(0, 0, 0);
    chk("s5_to1", 32'(timeout_count), 1);
    for (int j = 0; j < 35; j++) step(0, 0, 0);
    chk("s5_pre_state", 32'(state), 1);
    chk("s5_pre_counts", 32'({lock_loss_count, timeout_count}), 32'({2'd2, 2'd1}));
    step(0, 0, 1);
    chk("s5_clr_state", 32'(state), 0);
    chk("s5_clr_lol", 32'(lock_loss_count), 0);
    chk("s5_clr_to", 32'(timeout_count), 0);

    // Scenario 6: reset pulse in RUN with lock_loss_count = 2.
    wait_run("s6_run_a");
    drop_in_run("s6_a");
    wait_run("s6_run_b");
    drop_in_run("s6_b");
    wait_run("s6_run_c");
    chk("s6_lol2", 32'(lock_loss_count), 2);
    step(1, 1, 0);
    chk("s6_state", 32'(state), 0);
    chk("s6_pll_reset", 32'(pll_reset), 1);
    chk("s6_rst_out", 32'(rst_out), 1);
    chk("s6_ready", 32'(ready), 0);
    chk("s6_counts", 32'({lock_loss_count, timeout_count}), 0);

    // Randomised traffic against the reference model.
    step(1, 0, 0);
    seg_left = 0;
    lvl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (seg_left == 0) begin
        lvl = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
        seg_left = lvl ? $urandom_range(1, 80) : $urandom_range(1, 120);
      end
      seg_left--;
      step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0, lvl,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_lock_monitor.md
Name: pll_lock_monitor

Overview:
- Consumes the lock status of the board PLL and sequences resets for the clock domains it feeds.
- Pulses the PLL reset, waits for lock, and qualifies lock as stable for a programmable time before releasing the domain reset.
- Detects loss of lock and timeouts, then re-sequences from the start.
- Runs on the 200 MHz sys_clk.

Parameters:
- PLL_RST_CYCLES, 16, number of cycles pll_reset is held high per attempt (>=1)
- STABLE_CYCLES, 2000, consecutive cycles the synchronised lock must stay high before release (10 us at 200 MHz, >=1)
- LOCK_TIMEOUT, 200000, cycles allowed in WAIT_LOCK before retrying (1 ms, >=1)
- CNT_W, 8, width of the event counters

Ports:
- sys_clk  in  1  200 MHz system clock; the only clock
- reset  in  1  synchronous, active-high
- pll_locked  in  1  PLL lock, asynchronous to sys_clk
- clear_count  in  1  synchronous clear of both event counters
- pll_reset  out  1  drives the PLL reset input
- rst_out  out  1  active-high reset for downstream logic
- ready  out  1  high only in RUN
- state  out  2  current FSM state (encoding below)
- lock_loss_count  out  CNT_W  number of RUN->lock-lost events, saturating
- timeout_count  out  CNT_W  number of WAIT_LOCK timeouts, saturating

Behaviour:
- All outputs are registered or decoded from state. One clock, sys_clk. Reset is synchronous and active-high.
- Reset values:
  - state = RESET_PLL(0)
  - pll_reset = 1, rst_out = 1, ready = 0
  - timer = 0, both counters = 0, synchroniser flops = 0
- Synchroniser: pll_locked passes through two flops to give lk_s, so lk_s lags pll_locked by 2 cycles.
- Timer:
  - Cleared to 0 on every state entry; increments every cycle in that state.
  - Width = $clog2(max of the three cycle parameters) + 1.
- State encoding: RESET_PLL = 0, WAIT_LOCK = 1, STABLE = 2, RUN = 3.
- RESET_PLL:
  - Outputs: pll_reset = 1, rst_out = 1, ready = 0.
  - When timer == PLL_RST_CYCLES-1, go to WAIT_LOCK. pll_reset is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK:
  - Outputs: pll_reset = 0, rst_out = 1.
  - If lk_s = 1, go to STABLE.
  - Else if timer == LOCK_TIMEOUT-1, go to RESET_PLL and increment timeout_count.
  - If both conditions hold in the same cycle, lk_s wins.
- STABLE:
  - Outputs: pll_reset = 0, rst_out = 1.
  - If lk_s = 0, go to WAIT_LOCK (timer restarts). This is a glitch rejection, not a counted event.
  - Else if timer == STABLE_CYCLES-1, go to RUN.
- RUN:
  - Outputs: rst_out = 0, ready = 1, pll_reset = 0. These change on the same edge the state becomes RUN.
  - If lk_s = 0, go to RESET_PLL and increment lock_loss_count. rst_out = 1 on the same edge.
  - Worst case from pll_locked falling to rst_out high is 3 cycles: 2 sync + 1 register.
- Counters:
  - Saturate at 2^CNT_W-1.
  - clear_count = 1 forces both counters to 0; clear wins over a same-cycle increment.
  - clear_count has no effect on the FSM.
- reset asserted mid-operation (any state) returns everything to reset values on the next edge, including the counters.
- pll_locked toggling while in RESET_PLL is ignored.

Decomposition:
- Shared package pll_mon_pkg holds:
  - the state typedef/localparams (RESET_PLL, WAIT_LOCK, STABLE, RUN)
  - the default 200 MHz timing constants (CYC_PER_US = 200)
- One sub-module, sync_2ff: a generic 2-flop synchroniser, reset to 0, WIDTH parameter. It will be reused for other asynchronous status bits.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, CNT_W=2.
1. Release reset with pll_locked held 1 from the start:
   - pll_reset high for exactly 4 cycles.
   - STABLE entered 1 cycle after WAIT_LOCK entry (lk_s already 1).
   - rst_out falls and ready rises 8 cycles after STABLE entry.
2. pll_locked = 0 forever:
   - Cycle repeats RESET_PLL(4) -> WAIT_LOCK(32).
   - timeout_count reads 1, 2, 3, then holds at 3 (saturation).
3. In STABLE at timer = 5, drop pll_locked for 1 cycle:
   - FSM returns to WAIT_LOCK.
   - rst_out stays 1; no counter changes.
   - Relock gives a fresh 8-cycle qualification.
4. In RUN, drop pll_locked:
   - rst_out = 1 and state = RESET_PLL within 3 cycles.
   - lock_loss_count increments 0 -> 1.
   - pll_reset high for 4 cycles, then normal relock.
5. Assert clear_count in the same cycle as a timeout increment:
   - Both counters read 0 the next cycle.
   - FSM still goes to RESET_PLL.
6. Assert reset for 1 cycle while in RUN with lock_loss_count = 2:
   - Next cycle shows state 0, pll_reset = 1, rst_out = 1, ready = 0, counters 0.
